instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Parametrised instruction fetch/decode stage for the 8-bit ISA. It holds a loadable program memory and jump-label table, fetches one instruction per cycle from a PC register, and decodes it into format, opcode, register indices, immediate and resolved jump target. Decoded entries pass through a small FIFO to the execute stage over a valid/ready handshake. The stage supports redirect/flush, halts on HALT, and stops on out-of-range fetch.

## Interface
- `PC_W`, 16: PC and jump-target width.
- `MEM_AW`, 6: program memory address bits; memory is 2^MEM_AW x 8.
- `LBL_AW`, 4: label table address bits, minimum 4; table is 2^LBL_AW x PC_W.
- `QDEPTH`, 2: decoded-instruction FIFO depth, 1 to 8.
- `RESET_PC`, 0: PC after reset.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  fetch enable.
- `prog_we` / `prog_addr` / `prog_data`  in  1 / MEM_AW / 8  program memory write port.
- `lbl_we` / `lbl_addr` / `lbl_data`  in  1 / LBL_AW / PC_W  label table write port.
- `redirect_valid` / `redirect_pc`  in  1 / PC_W  flush and load a new PC.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_pc`  out  PC_W  address of the head instruction.
- `format`  out  2  C=00, I=01, M=10, X=11.
- `opcode`  out  4  instruction bits [7:4].
- `reg1_i`, `reg2_i`, `reg_o`  out  3 each  register indices.
- `imm`  out  3  instruction bits [3:1].
- `imm_flag`  out  1  instruction bit [0].
- `jmp_loc`  out  PC_W  resolved jump target.
- `halted`  out  1  HALT has been fetched; fetch is stopped.
- `oob`  out  1  sticky out-of-range fetch flag.

## Operation
- Reset values: PC=RESET_PC, FIFO empty, `out_valid`=0, all decode outputs 0, `halted`=0, `oob`=0. Memory and label contents are not reset.
- Fetch condition, per cycle: `run` & !`halted` & !`oob` & !`redirect_valid` & (count<QDEPTH or head popped this cycle).
- Fetch: read mem[PC] combinationally, decode, push the decoded entry, PC <= PC+1 (wraps at 2^PC_W).
- Out-of-range: if PC >= 2^MEM_AW under the fetch condition, set `oob`, push nothing, hold PC.
- Format by opcode:
  - 0,1,3,5,6,7,8,A,B,C → M.
  - 2,4 → C.
  - 9,D → I.
  - E,F → X.
- Register decode. Unused fields are 0, never X. Sums are 3-bit and wrap (7+1=0).
  - C: `reg_o` = instr[0] ? 3 : 2.
  - I: `reg1_i` = instr[3:1], `reg2_i` = `reg1_i`+1, `reg_o` = `reg1_i`.
  - M with opcode 5 (MVB): `reg1_i` = {1,instr[1:0]}, `reg_o` = {0,instr[3:2]}.
  - M otherwise: `reg1_i` = {0,instr[3:2]}, `reg2_i` = `reg1_i`+1, `reg_o` = {1,instr[1:0]}.
- `jmp_loc`:
  - C: label[instr[3:0]].
  - M: label[{2'b11,instr[1:0]}].
  - I and X: 0.
  - Label indices are zero-extended to LBL_AW. The label is sampled at fetch time and frozen in the FIFO entry.
- HALT (opcode E): the entry is pushed normally, and `halted` sets in the same edge. `halted` clears only on redirect or reset.
- Redirect: FIFO flushed, PC <= `redirect_pc`, `halted` and `oob` cleared, no fetch that cycle. A head handshake in the same cycle counts as consumed by the consumer; the flush still drops it from the FIFO.
- Writes: `prog_we` and `lbl_we` commit on the edge. A fetch of the same address in the same cycle sees the old data.
- `out_valid` = FIFO not empty. Decode outputs show the head entry, or 0 when empty. The head is stable while `out_valid` & !`out_ready`.

## Timing
- Redirect asserted in cycle N: PC=target in N+1; first entry has `out_valid`=1 in N+2.
- Throughput: 1 instruction/cycle when `out_ready`=1 continuously.
- With QDEPTH=2 and `out_ready` low, the FIFO fills in 2 fetch cycles, then PC holds.
- Push and pop in the same cycle when full is allowed; count is unchanged.
- Reset asserted mid-operation clears all state immediately (asynchronously). Fetch resumes on the first edge after `rst_n` rises with `run`=1.

## Test plan
- Load mem[0]=0x4F, mem[1]=0x79, mem[2]=0x5A, label[15]=0x000A, then `run` with `out_ready`=1. Required outputs:
  - 0x4F: C, `reg_o`=3, `jmp_loc`=0x000A.
  - 0x79: M, r1=2, r2=3, ro=5.
  - 0x5A: MVB, r1=6, ro=2.
  - `out_pc` 0,1,2 on consecutive cycles.
- mem[0]=0xDE (I, r1=7), then mem[1]=0xE0 (HALT). Required: r2=0 (wrap), ro=7; then the HALT entry with format X; `halted`=1; PC holds at 2.
- `out_ready`=0 with QDEPTH=2. Required: exactly 2 entries queued, PC=2, head held stable. Release `out_ready`: entries drain in order with no loss or duplication.
- After HALT, `redirect_valid`=1 with `redirect_pc`=0x0010 while the FIFO holds 2 entries. Required: `out_valid`=0 the next cycle, `halted`=0, and the first entry has `out_pc`=0x0010 two cycles after the redirect.
- With MEM_AW=6, redirect to 0x0040. Required: `oob`=1, no entries pushed; a redirect to 0x0000 clears `oob`.
- Reset asserted mid-stream with `rst_n`=0. Required: `out_valid`, `halted`, `oob` and all decode outputs go to 0 immediately, and PC=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/decode stage: program memory and label table, PC-driven fetch,
// decode into format/registers/immediate/jump target, and a small output FIFO.
module instr_fetch_unit #(
   parameter int PC_W   = 16,
   parameter int MEM_AW = 6,
   parameter int LBL_AW = 4,
   parameter int QDEPTH = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              prog_we,
   input  logic [MEM_AW-1:0] prog_addr,
   input  logic [7:0]        prog_data,
   input  logic              lbl_we,
   input  logic [LBL_AW-1:0] lbl_addr,
   input  logic [PC_W-1:0]   lbl_data,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [1:0]        format,
   output logic [3:0]        opcode,
   output logic [2:0]        reg1_i,
   output logic [2:0]        reg2_i,
   output logic [2:0]        reg_o,
   output logic [2:0]        imm,
   output logic              imm_flag,
   output logic [PC_W-1:0]   jmp_loc,
   output logic              halted,
   output logic              oob
);

   localparam logic [1:0] FMT_C = 2'b00;
   localparam logic [1:0] FMT_I = 2'b01;
   localparam logic [1:0] FMT_M = 2'b10;
   localparam logic [1:0] FMT_X = 2'b11;

   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [1:0]      fmt;
      logic [3:0]      opc;
      logic [2:0]      r1;
      logic [2:0]      r2;
      logic [2:0]      ro;
      logic [2:0]      imm;
      logic            immf;
      logic [PC_W-1:0] jmp;
   } entry_t;

   logic [7:0]        prog_mem [2**MEM_AW];
   logic [PC_W-1:0]   lbl_mem  [2**LBL_AW];
   entry_t            fifo_mem [QDEPTH];

   logic [PC_W-1:0]   pc_reg;
   logic              halted_reg;
   logic              oob_reg;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;

   logic [7:0]        instr;
   logic [LBL_AW-1:0] lbl_idx;
   entry_t            dec;
   entry_t            head;
   logic              pc_oob;
   logic              pop, fetch_go, push;

   always_ff @(posedge clk) begin
      if (prog_we)
         prog_mem[prog_addr] <= prog_data;
      if (lbl_we)
         lbl_mem[lbl_addr] <= lbl_data;
   end

   // Fetch is out of range whenever any PC bit above the memory address field is set.
   generate
      if (PC_W > MEM_AW) begin : g_oob_chk
         assign pc_oob = |pc_reg[PC_W-1:MEM_AW];
      end else begin : g_no_oob_chk
         assign pc_oob = 1'b0;
      end
   endgenerate

   assign instr = prog_mem[pc_reg[MEM_AW-1:0]];

   always_comb begin
      dec      = '0;
      lbl_idx  = '0;
      dec.pc   = pc_reg;
      dec.opc  = instr[7:4];
      dec.imm  = instr[3:1];
      dec.immf = instr[0];
      case (instr[7:4])
         4'h2, 4'h4: dec.fmt = FMT_C;
         4'h9, 4'hD: dec.fmt = FMT_I;
         4'hE, 4'hF: dec.fmt = FMT_X;
         default:    dec.fmt = FMT_M;
      endcase
      case (dec.fmt)
         FMT_C: begin
            dec.ro  = instr[0] ? 3'd3 : 3'd2;
            lbl_idx = LBL_AW'(instr[3:0]);
            dec.jmp = lbl_mem[lbl_idx];
         end
         FMT_I: begin
            dec.r1 = instr[3:1];
            dec.r2 = instr[3:1] + 3'd1;
            dec.ro = instr[3:1];
         end
         FMT_M: begin
            if (instr[7:4] == 4'h5) begin
               dec.r1 = {1'b1, instr[1:0]};
               dec.ro = {1'b0, instr[3:2]};
            end else begin
               dec.r1 = {1'b0, instr[3:2]};
               dec.r2 = {1'b0, instr[3:2]} + 3'd1;
               dec.ro = {1'b1, instr[1:0]};
            end
            lbl_idx = LBL_AW'({2'b11, instr[1:0]});
            dec.jmp = lbl_mem[lbl_idx];
         end
         default: ;
      endcase
   end

   assign out_valid = (count_reg != '0);
   assign pop       = out_valid & out_ready;
   assign fetch_go  = run & ~halted_reg & ~oob_reg & ~redirect_valid &
                      ((count_reg < CNT_W'(QDEPTH)) | pop);
   assign push      = fetch_go & ~pc_oob;

   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + 1'b1;
      else if (!push && pop)
         count_next = count_reg - 1'b1;
   end

   generate
      for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == PTR_W'(gi))
               fifo_mem[gi] <= dec;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg     <= RESET_PC;
         halted_reg <= 1'b0;
         oob_reg    <= 1'b0;
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (redirect_valid) begin
         pc_reg     <= redirect_pc;
         halted_reg <= 1'b0;
         oob_reg    <= 1'b0;
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         count_reg <= count_next;
         if (fetch_go && pc_oob)
            oob_reg <= 1'b1;
         if (push) begin
            pc_reg     <= pc_reg + 1'b1;
            wr_ptr_reg <= (wr_ptr_reg == PTR_W'(QDEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (instr[7:4] == 4'hE)
               halted_reg <= 1'b1;
         end
         if (pop)
            rd_ptr_reg <= (rd_ptr_reg == PTR_W'(QDEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
   end

   // Empty FIFO presents all-zero decode fields rather than stale slot contents.
   assign head     = out_valid ? fifo_mem[rd_ptr_reg] : '0;
   assign out_pc   = head.pc;
   assign format   = head.fmt;
   assign opcode   = head.opc;
   assign reg1_i   = head.r1;
   assign reg2_i   = head.r2;
   assign reg_o    = head.ro;
   assign imm      = head.imm;
   assign imm_flag = head.immf;
   assign jmp_loc  = head.jmp;
   assign halted   = halted_reg;
   assign oob      = oob_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: decode, halt, back-pressure, redirect,
// out-of-range and asynchronous reset, with hand-computed expectations.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        prog_we = 1'b0;
   logic [5:0]  prog_addr = '0;
   logic [7:0]  prog_data = '0;
   logic        lbl_we = 1'b0;
   logic [3:0]  lbl_addr = '0;
   logic [15:0] lbl_data = '0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_pc;
   logic [1:0]  format;
   logic [3:0]  opcode;
   logic [2:0]  reg1_i, reg2_i, reg_o, imm;
   logic        imm_flag;
   logic [15:0] jmp_loc;
   logic        halted, oob;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_data(lbl_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .format(format), .opcode(opcode), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .reg_o(reg_o), .imm(imm), .imm_flag(imm_flag), .jmp_loc(jmp_loc),
      .halted(halted), .oob(oob)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
         $display("ok   %s: %0h", tag, got);
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wprog(input logic [5:0] a, input logic [7:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic wlbl(input logic [3:0] a, input logic [15:0] d);
      lbl_we = 1'b1; lbl_addr = a; lbl_data = d;
      tick();
      lbl_we = 1'b0;
   endtask

   task automatic redirect(input logic [15:0] p);
      redirect_valid = 1'b1; redirect_pc = p;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      check("rst_valid",  32'(out_valid), 32'd0);
      check("rst_halted", 32'(halted),    32'd0);
      check("rst_oob",    32'(oob),       32'd0);
      check("rst_fmt",    32'(format),    32'd0);
      check("rst_jmp",    32'(jmp_loc),   32'd0);
      check("rst_pc",     32'(dut.pc_reg), 32'd0);
      tick();
      rst_n = 1'b1;

      // Basic decode stream with continuous ready
      wprog(6'd0, 8'h4F); wprog(6'd1, 8'h79); wprog(6'd2, 8'h5A); wprog(6'd3, 8'hE0);
      wlbl(4'd15, 16'h000A); wlbl(4'd13, 16'h0033); wlbl(4'd14, 16'h0044);
      out_ready = 1'b1; run = 1'b1;
      tick();
      check("s1_valid", 32'(out_valid), 32'd1);
      check("s1_pc0",   32'(out_pc),    32'd0);
      check("s1_fmtC",  32'(format),    32'd0);
      check("s1_ro3",   32'(reg_o),     32'd3);
      check("s1_jmpA",  32'(jmp_loc),   32'h000A);
      tick();
      check("s1_pc1",   32'(out_pc),    32'd1);
      check("s1_fmtM",  32'(format),    32'd2);
      check("s1_r1_2",  32'(reg1_i),    32'd2);
      check("s1_r2_3",  32'(reg2_i),    32'd3);
      check("s1_ro5",   32'(reg_o),     32'd5);
      check("s1_jmp33", 32'(jmp_loc),   32'h0033);
      tick();
      check("s1_pc2",   32'(out_pc),    32'd2);
      check("s1_mvbfmt",32'(format),    32'd2);
      check("s1_mvb_r1",32'(reg1_i),    32'd6);
      check("s1_mvb_r2",32'(reg2_i),    32'd0);
      check("s1_mvb_ro",32'(reg_o),     32'd2);
      check("s1_jmp44", 32'(jmp_loc),   32'h0044);
      tick();
      check("s1_halt_fmt", 32'(format), 32'd3);
      check("s1_halted",   32'(halted), 32'd1);
      tick();
      check("s1_empty",  32'(out_valid),  32'd0);
      check("s1_pchold", 32'(dut.pc_reg), 32'd4);

      // I-format with register wrap, then HALT
      run = 1'b0;
      wprog(6'd0, 8'hDE); wprog(6'd1, 8'hE0);
      run = 1'b1;
      redirect(16'h0000);
      check("s2_pc0",     32'(dut.pc_reg), 32'd0);
      check("s2_unhalt",  32'(halted),     32'd0);
      check("s2_novalid", 32'(out_valid),  32'd0);
      tick();
      check("s2_fmtI", 32'(format),  32'd1);
      check("s2_r1_7", 32'(reg1_i),  32'd7);
      check("s2_r2_0", 32'(reg2_i),  32'd0);
      check("s2_ro7",  32'(reg_o),   32'd7);
      check("s2_imm7", 32'(imm),     32'd7);
      check("s2_jmp0", 32'(jmp_loc), 32'd0);
      tick();
      check("s2_fmtX",   32'(format),     32'd3);
      check("s2_opcE",   32'(opcode),     32'hE);
      check("s2_halted", 32'(halted),     32'd1);
      check("s2_pc2",    32'(dut.pc_reg), 32'd2);
      tick();
      check("s2_empty",  32'(out_valid),  32'd0);
      check("s2_pchold", 32'(dut.pc_reg), 32'd2);

      // Back-pressure fill, then drain in order
      run = 1'b0;
      wprog(6'd0, 8'h79); wprog(6'd1, 8'h5A); wprog(6'd2, 8'hE0);
      out_ready = 1'b0; run = 1'b1;
      redirect(16'h0000);
      tick();
      check("s3_v1",   32'(out_valid), 32'd1);
      check("s3_head", 32'(out_pc),    32'd0);
      tick();
      check("s3_cnt2", 32'(dut.count_reg), 32'd2);
      check("s3_pc2",  32'(dut.pc_reg),    32'd2);
      tick();
      check("s3_pchold", 32'(dut.pc_reg), 32'd2);
      check("s3_stable", 32'(out_pc),     32'd0);
      check("s3_stro",   32'(reg_o),      32'd5);
      out_ready = 1'b1;
      tick();
      check("s3_d1_pc",  32'(out_pc),        32'd1);
      check("s3_full_pp",32'(dut.count_reg), 32'd2);
      check("s3_d1_fmt", 32'(format),        32'd2);
      tick();
      check("s3_d2_pc",  32'(out_pc),  32'd2);
      check("s3_d2_fmt", 32'(format),  32'd3);
      tick();
      check("s3_drained", 32'(out_valid), 32'd0);

      // Redirect while halted with a full FIFO
      run = 1'b0;
      wprog(6'd1, 8'hE0); wprog(6'h10, 8'h29); wlbl(4'd9, 16'h0123);
      out_ready = 1'b0; run = 1'b1;
      redirect(16'h0000);
      tick(); tick();
      check("s4_cnt2",   32'(dut.count_reg), 32'd2);
      check("s4_halted", 32'(halted),        32'd1);
      redirect(16'h0010);
      check("s4_flush",  32'(out_valid),  32'd0);
      check("s4_unhalt", 32'(halted),     32'd0);
      check("s4_pc10",   32'(dut.pc_reg), 32'h10);
      tick();
      check("s4_valid",  32'(out_valid), 32'd1);
      check("s4_outpc",  32'(out_pc),    32'h10);
      check("s4_fmtC",   32'(format),    32'd0);
      check("s4_jmp123", 32'(jmp_loc),   32'h0123);

      // Out-of-range fetch
      out_ready = 1'b1;
      redirect(16'h0040);
      check("s5_pc40",  32'(dut.pc_reg), 32'h40);
      check("s5_noob0", 32'(oob),        32'd0);
      tick();
      check("s5_oob",   32'(oob),        32'd1);
      check("s5_nopush",32'(out_valid),  32'd0);
      tick();
      check("s5_hold",  32'(dut.pc_reg), 32'h40);
      check("s5_empty", 32'(out_valid),  32'd0);
      redirect(16'h0000);
      check("s5_clear", 32'(oob),        32'd0);

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      tick(); tick();
      check("s6_pre_halt", 32'(halted), 32'd1);
      check("s6_pre_ro",   32'(reg_o),  32'd5);
      #3;
      rst_n = 1'b0;
      #1;
      check("s6_valid",  32'(out_valid),  32'd0);
      check("s6_halted", 32'(halted),     32'd0);
      check("s6_oob",    32'(oob),        32'd0);
      check("s6_fmt",    32'(format),     32'd0);
      check("s6_r1",     32'(reg1_i),     32'd0);
      check("s6_ro",     32'(reg_o),      32'd0);
      check("s6_opc",    32'(opcode),     32'd0);
      check("s6_pc",     32'(dut.pc_reg), 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      check("s6_resume_v",  32'(out_valid), 32'd1);
      check("s6_resume_pc", 32'(out_pc),    32'd0);
      check("s6_resume_fmt",32'(format),    32'd2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
